adc_serial_multi: RTL and testbench
===================================

Name: adc_serial_multi

Overview:
Parametrised successor to the single-channel serial ADC reader. It drives one shared adc_clk/adc_cs pair for NUM_CH ADS7883-style SAR ADCs with independent serial data lines, and deserialises each channel MSB-first. It presents all channels simultaneously with a one-cycle valid strobe and tracks a per-channel running maximum. It adds a programmable ADC clock divider, run/stop control and a clearable peak hold, and sits between the ADC pins and the FFT sample input.

Parameters:
NUM_CH, 2, number of ADC channels sharing clk/cs (>=1)
DATA_W, 12, bits per sample (>=4)
LEAD_BITS, 2, blank adc_clk periods after CS falls, discarded
FRAME_LEN, 16, adc_clk periods per conversion frame (>= DATA_W+LEAD_BITS+2)
CLK_DIV, 2, system clocks per adc_clk period (even, >=2)
AVG_LOG2, 2, log2 of frames averaged (used only with ADC_AVG_EN)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  run request; sampled at frame boundary
max_clr  in  1  clears all max registers
adc_sd  in  NUM_CH  serial data, bit i = channel i
adc_clk  out  1  registered ADC clock
adc_cs  out  1  registered chip select, active low
ready  out  1  one-cycle pulse: data valid
data  out  NUM_CH*DATA_W  channel i at [i*DATA_W +: DATA_W]
max  out  NUM_CH*DATA_W  per-channel peak, same packing
busy  out  1  high while a frame is in progress

Behaviour:
- Reset values: adc_clk=1, adc_cs=1, ready=0, data=0, max=0, busy=0; divider, slot and shift registers cleared. Reset mid-frame abandons the frame with no ready pulse; adc_cs=1 on the cycle after reset is sampled.
- Divider: div_cnt counts 0..CLK_DIV-1 while busy. adc_clk=1 for div_cnt<CLK_DIV/2, 0 otherwise, registered with no glitches. A bit strobe occurs when div_cnt==CLK_DIV-1; adc_sd is sampled on that cycle, i.e. immediately before the adc_clk rise.
- States: IDLE, FRAME.
  - IDLE: adc_clk=1, adc_cs=1, busy=0. If enable=1, go to FRAME with slot=0 and div_cnt=0.
  - FRAME: slot counts 0..FRAME_LEN-1 and advances on each strobe.
- Slot actions:
  - Slot 0: adc_cs=1; shift registers cleared.
  - Slots 1..FRAME_LEN-1: adc_cs=0.
  - Slots 1..LEAD_BITS: ignored.
  - Slots LEAD_BITS+1..LEAD_BITS+DATA_W: on each strobe, shift[i] <= {shift[i][DATA_W-2:0], adc_sd[i]}.
- Publish: on the system cycle after the strobe of the last capture slot, data <= shift registers and ready=1 for exactly one clk. Update max[i] where shift[i] > max[i] (unsigned compare).
- Frame end: at the strobe of slot FRAME_LEN-1, go to slot 0 if enable=1, else go to IDLE. Deasserting enable mid-frame never truncates the frame.
- max_clr: sets all max to 0. If it coincides with a publish, max[i] <= new sample (clear then compare).
- Latency: first ready occurs CLK_DIV*(LEAD_BITS+DATA_W+1)+1 clks after the FRAME entry cycle. Sample rate is clk/(CLK_DIV*FRAME_LEN).
- data holds its value between ready pulses. ready never stays high for two consecutive cycles.

Optional Feature:
ADC_AVG_EN:
- Defined: each channel has a (DATA_W+AVG_LOG2)-bit accumulator that sums 2^AVG_LOG2 consecutive samples. On the last sample of the group, data <= accumulator >> AVG_LOG2 (truncating) and ready pulses; the accumulator restarts from 0. ready therefore pulses once per 2^AVG_LOG2 frames. max still tracks raw per-frame samples. Reset and IDLE entry clear the accumulators and group counter, discarding any partial group.
- Undefined: no accumulators; ready pulses every frame with raw samples.

Test Plan:
- Defaults, enable=1 from reset release, ch0 serialises 0xA5C and ch1 0x123 in slots 3..14 -> ready at cycle 31 after FRAME entry; data=0x123_A5C; cs=1 only in slot 0.
- Three frames with ch0 = 0x100, 0x7FF, 0x200 -> max[ch0]=0x7FF after frame 2 and unchanged after frame 3; data=0x200.
- max_clr on the same cycle as a publish of ch0=0x050 with prior max 0x7FF -> max[ch0]=0x050.
- Drop enable at slot 5 -> frame completes, one ready pulse, then IDLE with adc_cs=1, adc_clk=1, busy=0 and no further strobes.
- Reset asserted at slot 8 -> next cycle adc_cs=1, ready=0, data=0, max=0; no publish occurs.
- ADC_AVG_EN, AVG_LOG2=2, ch0 samples 10, 11, 12, 14 -> single ready after frame 4 with data[ch0]=11 (47>>2); no ready on frames 1-3.

Source files
------------

// File: rtl/adc_serial_multi.sv
// adc_serial_multi
//   Drives one shared adc_clk / adc_cs pair for NUM_CH ADS7883-style SAR ADCs.
//   Each ADC has its own serial data line, and each channel is deserialised
//   MSB-first. All channels are published together with a one-cycle ready
//   strobe, and a per-channel running maximum is kept alongside.
//
// Ports
//   clk      in   system clock
//   reset    in   synchronous, active-high reset
//   enable   in   run request, sampled at the frame boundary
//   max_clr  in   clears every peak register (a publish on the same cycle wins)
//   adc_sd   in   [NUM_CH]          serial data, bit i = channel i
//   adc_clk  out  registered ADC clock, idles high
//   adc_cs   out  registered chip select, active low
//   ready    out  one-cycle pulse, data is valid
//   data     out  [NUM_CH*DATA_W]  channel i at [i*DATA_W +: DATA_W]
//   max      out  [NUM_CH*DATA_W]  per-channel peak, same packing
//   busy     out  high while a frame is in progress
//
// Optional build macro
//   ADC_AVG_EN : when defined, 2**AVG_LOG2 consecutive frames are averaged per
//                channel, and ready pulses once per group. The peak registers
//                still follow the raw per-frame samples.
module adc_serial_multi #(
  parameter int NUM_CH    = 2,
  parameter int DATA_W    = 12,
  parameter int LEAD_BITS = 2,
  parameter int FRAME_LEN = 16,
  parameter int CLK_DIV   = 2,
  parameter int AVG_LOG2  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       max_clr,
  input  logic [NUM_CH-1:0]          adc_sd,
  output logic                       adc_clk,
  output logic                       adc_cs,
  output logic                       ready,
  output logic [NUM_CH*DATA_W-1:0]   data,
  output logic [NUM_CH*DATA_W-1:0]   max,
  output logic                       busy
);

  localparam int DIV_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int SLOT_W = $clog2(FRAME_LEN);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(CLK_DIV / 2);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FRAME_LEN - 1);
  localparam logic [SLOT_W-1:0] CAP_FIRST = SLOT_W'(LEAD_BITS + 1);
  localparam logic [SLOT_W-1:0] CAP_LAST  = SLOT_W'(LEAD_BITS + DATA_W);

  typedef enum logic {IDLE, FRAME} state_t;

  state_t                          state_q, state_d;
  logic [DIV_W-1:0]                div_cnt_q, div_cnt_d;
  logic [SLOT_W-1:0]               slot_q, slot_d;
  logic [NUM_CH-1:0][DATA_W-1:0]   shift_q, shift_d;
  logic [NUM_CH-1:0][DATA_W-1:0]   data_q, data_d;
  logic [NUM_CH-1:0][DATA_W-1:0]   max_q, max_d;
  logic                            pub_q, pub_d;
  logic                            ready_q, ready_d;
  logic                            adc_clk_q, adc_clk_d;
  logic                            adc_cs_q, adc_cs_d;
  logic                            strobe;

`ifdef ADC_AVG_EN
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int GRP_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'((1 << AVG_LOG2) - 1);

  logic [NUM_CH-1:0][ACC_W-1:0]    acc_q, acc_d;
  logic [GRP_W-1:0]                grp_q, grp_d;
  logic [ACC_W-1:0]                sum;
`endif

  // The ADC pins are registered copies of the next-state values. Because of
  // that, adc_clk and adc_cs line up with div_cnt_q and slot_q and never glitch.
  // pub_q delays the publish by one cycle so that it follows the last capture strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      div_cnt_q <= '0;
      slot_q    <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      max_q     <= '0;
      pub_q     <= 1'b0;
      ready_q   <= 1'b0;
      adc_clk_q <= 1'b1;
      adc_cs_q  <= 1'b1;
`ifdef ADC_AVG_EN
      acc_q     <= '0;
      grp_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      slot_q    <= slot_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      max_q     <= max_d;
      pub_q     <= pub_d;
      ready_q   <= ready_d;
      adc_clk_q <= adc_clk_d;
      adc_cs_q  <= adc_cs_d;
`ifdef ADC_AVG_EN
      acc_q     <= acc_d;
      grp_q     <= grp_d;
`endif
    end
  end

  // Next-state logic for the frame sequencer, the shifters and the publish path.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    slot_d    = slot_q;
    shift_d   = shift_q;
    data_d    = data_q;
    max_d     = max_q;
    ready_d   = 1'b0;
    strobe    = (state_q == FRAME) && (div_cnt_q == DIV_LAST);
`ifdef ADC_AVG_EN
    acc_d     = acc_q;
    grp_d     = grp_q;
    sum       = '0;
`endif

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d   = FRAME;
          div_cnt_d = '0;
          slot_d    = '0;
        end
      end
      FRAME: begin
        div_cnt_d = strobe ? '0 : div_cnt_q + 1'b1;
        if (strobe) begin
          // enable is only looked at here, so a frame that has started always finishes.
          if (slot_q == SLOT_LAST) begin
            slot_d = '0;
            if (!enable) state_d = IDLE;
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (slot_q == '0) begin
      shift_d = '0;
    end else if (strobe && (slot_q >= CAP_FIRST) && (slot_q <= CAP_LAST)) begin
      for (int i = 0; i < NUM_CH; i++)
        shift_d[i] = {shift_q[i][DATA_W-2:0], adc_sd[i]};
    end

    pub_d = strobe && (slot_q == CAP_LAST);

    // The clear is applied first and the compare second. A clear that lands
    // on a publish therefore leaves the new sample in the peak register.
    if (max_clr) max_d = '0;
    if (pub_q) begin
      for (int i = 0; i < NUM_CH; i++)
        if (shift_q[i] > max_d[i]) max_d[i] = shift_q[i];
    end

`ifdef ADC_AVG_EN
    // Any partial group is discarded whenever the sequencer sits idle.
    if (state_q == IDLE) begin
      acc_d = '0;
      grp_d = '0;
    end else if (pub_q) begin
      for (int i = 0; i < NUM_CH; i++) begin
        sum = acc_q[i] + ACC_W'(shift_q[i]);
        if (grp_q == GRP_LAST) begin
          data_d[i] = DATA_W'(sum >> AVG_LOG2);
          acc_d[i]  = '0;
        end else begin
          acc_d[i]  = sum;
        end
      end
      if (grp_q == GRP_LAST) begin
        ready_d = 1'b1;
        grp_d   = '0;
      end else begin
        grp_d   = grp_q + 1'b1;
      end
    end
`else
    if (pub_q) begin
      data_d  = shift_q;
      ready_d = 1'b1;
    end
`endif

    adc_clk_d = (state_d != FRAME) || (div_cnt_d < DIV_HALF);
    adc_cs_d  = (state_d != FRAME) || (slot_d == '0);
  end

  assign adc_clk = adc_clk_q;
  assign adc_cs  = adc_cs_q;
  assign ready   = ready_q;
  assign data    = data_q;
  assign max     = max_q;
  assign busy    = (state_q == FRAME);

endmodule

// File: tb/tb_adc_serial_multi.sv
// Testbench for adc_serial_multi with the default parameters.
// An ADC model shifts a queued word per channel onto adc_sd for each frame.
// Expected publishes go into a scoreboard queue, and a separate monitor pops
// and compares them whenever ready pulses.
module tb_adc_serial_multi;

  localparam int NUM_CH    = 2;
  localparam int DATA_W    = 12;
  localparam int LEAD_BITS = 2;
  localparam int FRAME_LEN = 16;
  localparam int CLK_DIV   = 2;
  localparam int AVG_LOG2  = 2;

  typedef struct {
    logic [NUM_CH*DATA_W-1:0] data;
    logic [NUM_CH*DATA_W-1:0] max;
  } exp_t;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       enable;
  logic                       max_clr;
  logic [NUM_CH-1:0]          adc_sd = '0;
  logic                       adc_clk;
  logic                       adc_cs;
  logic                       ready;
  logic [NUM_CH*DATA_W-1:0]   data_out;
  logic [NUM_CH*DATA_W-1:0]   max_out;
  logic                       busy;

  int checks = 0;
  int errors = 0;

  exp_t                       exp_q[$];
  exp_t                       cur_exp;
  logic [NUM_CH*DATA_W-1:0]   adc_words[$];
  logic [NUM_CH*DATA_W-1:0]   cur_word = '0;
  int                         bit_slot = 0;
  logic                       prev_cs = 1'b1;
  logic                       prev_aclk = 1'b1;
  int                         clk_fall_count = 0;
  logic                       prev_ready = 1'b0;
  int                         ready_count = 0;
  int                         cyc = 0;
  bit                         got_entry = 1'b0;
  bit                         got_ready = 1'b0;
  int                         entry_cyc = 0;
  int                         ready_cyc = 0;
  int                         cs_hi_busy = 0;
  int                         clk_lo_busy = 0;
  int                         fall_snap;
  int                         ready_snap;

  adc_serial_multi #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .LEAD_BITS(LEAD_BITS),
    .FRAME_LEN(FRAME_LEN), .CLK_DIV(CLK_DIV), .AVG_LOG2(AVG_LOG2)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .max_clr(max_clr),
    .adc_sd(adc_sd), .adc_clk(adc_clk), .adc_cs(adc_cs), .ready(ready),
    .data(data_out), .max(max_out), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // ADC model: a falling chip select loads the next queued word. Each later
  // falling adc_clk then presents the bit that belongs to the current slot.
  always @(posedge clk) begin
    #1;
    if (prev_cs && !adc_cs) begin
      bit_slot = 0;
      if (adc_words.size() > 0) cur_word = adc_words.pop_front();
      else cur_word = '0;
    end
    if (prev_aclk && !adc_clk) begin
      clk_fall_count++;
      if (!adc_cs) begin
        bit_slot++;
        for (int c = 0; c < NUM_CH; c++) begin
          if (bit_slot >= LEAD_BITS + 1 && bit_slot <= LEAD_BITS + DATA_W)
            adc_sd[c] = cur_word[c*DATA_W + (DATA_W - 1 - (bit_slot - LEAD_BITS - 1))];
          else
            adc_sd[c] = 1'b0;
        end
      end
    end
    prev_cs   = adc_cs;
    prev_aclk = adc_clk;
  end

  // Records the first-frame latency and the adc_cs/adc_clk duty inside frames.
  always @(negedge clk) begin
    if (busy === 1'b1 && !got_entry) begin
      got_entry = 1'b1;
      entry_cyc = cyc;
    end
    if (ready === 1'b1 && !got_ready) begin
      got_ready = 1'b1;
      ready_cyc = cyc;
    end
    if (busy === 1'b1 && adc_cs === 1'b1) cs_hi_busy++;
    if (busy === 1'b1 && adc_clk === 1'b0) clk_lo_busy++;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Monitor: every ready pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      ready_count++;
      checkOutput("ready_single_cycle", 64'(prev_ready), 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_ready actual=1 expected=0 data=%0h", data_out);
      end else begin
        cur_exp = exp_q.pop_front();
        checkOutput("data", 64'(data_out), 64'(cur_exp.data));
        checkOutput("max", 64'(max_out), 64'(cur_exp.max));
      end
    end
    prev_ready = ready;
  end

  task automatic applyStimulus(input logic [DATA_W-1:0] ch0, input logic [DATA_W-1:0] ch1,
                               input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                               input logic [DATA_W-1:0] m0, input logic [DATA_W-1:0] m1,
                               input bit publish);
    exp_t e;
    adc_words.push_back({ch1, ch0});
    if (publish) begin
      e.data = {d1, d0};
      e.max  = {m1, m0};
      exp_q.push_back(e);
    end
  endtask

  task automatic waitCsFall();
    int   g = 0;
    logic p;
    p = adc_cs;
    @(negedge clk);
    while (!(p === 1'b1 && adc_cs === 1'b0) && g < 100) begin
      p = adc_cs;
      @(negedge clk);
      g++;
    end
    checkOutput("cs_fall_seen", 64'(adc_cs), 64'd0);
  endtask

  // Runs n back-to-back frames and drops enable in slot drop_slot of the last one.
  task automatic runFrames(input int n, input int drop_slot);
    int g = 0;
    enable = 1'b1;
    for (int f = 0; f < n; f++) waitCsFall();
    repeat ((drop_slot - 1) * CLK_DIV) @(negedge clk);
    enable = 1'b0;
    while (busy === 1'b1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    checkOutput("frame_end_idle", 64'(busy), 64'd0);
  endtask

  task automatic clearOnPublish();
    int g = 0;
    do begin
      @(posedge clk);
      #1;
      g++;
    end while (ready !== 1'b1 && g < 200);
    max_clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    max_clr = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_adc_clk", 64'(adc_clk), 64'd1);
    checkOutput("rst_adc_cs", 64'(adc_cs), 64'd1);
    checkOutput("rst_ready", 64'(ready), 64'd0);
    checkOutput("rst_data", 64'(data_out), 64'd0);
    checkOutput("rst_max", 64'(max_out), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);

`ifdef ADC_AVG_EN
    // ch0 10,11,12,14 -> 47>>2 = 11 ; ch1 4,8,12,16 -> 40>>2 = 10
    applyStimulus(12'd10, 12'd4,  12'd0,  12'd0,  12'd0,  12'd0,  1'b0);
    applyStimulus(12'd11, 12'd8,  12'd0,  12'd0,  12'd0,  12'd0,  1'b0);
    applyStimulus(12'd12, 12'd12, 12'd0,  12'd0,  12'd0,  12'd0,  1'b0);
    applyStimulus(12'd14, 12'd16, 12'd11, 12'd10, 12'd14, 12'd16, 1'b1);
    reset = 1'b0;
    runFrames(4, 1);
    repeat (10) @(negedge clk);
    checkOutput("ready_pulses", 64'(ready_count), 64'd1);
`else
    // First frame straight from reset release.
    applyStimulus(12'hA5C, 12'h123, 12'hA5C, 12'h123, 12'hA5C, 12'h123, 1'b1);
    reset = 1'b0;
    runFrames(1, 1);
    checkOutput("first_latency", 64'(ready_cyc - entry_cyc), 64'd31);
    checkOutput("cs_high_cycles", 64'(cs_hi_busy), 64'd2);
    checkOutput("adc_clk_low_cycles", 64'(clk_lo_busy), 64'd16);
    checkOutput("idle_adc_clk", 64'(adc_clk), 64'd1);

    // A reset pulse while idle clears data and max.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst2_data", 64'(data_out), 64'd0);
    checkOutput("rst2_max", 64'(max_out), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Peak tracking over three frames.
    applyStimulus(12'h100, 12'h010, 12'h100, 12'h010, 12'h100, 12'h010, 1'b1);
    applyStimulus(12'h7FF, 12'h020, 12'h7FF, 12'h020, 12'h7FF, 12'h020, 1'b1);
    applyStimulus(12'h200, 12'h008, 12'h200, 12'h008, 12'h7FF, 12'h020, 1'b1);
    runFrames(3, 1);
    repeat (5) @(negedge clk);
    checkOutput("data_hold", 64'(data_out), 64'h008200);
    checkOutput("max_before_clr", 64'(max_out), 64'h0207FF);

    // max_clr held through the publish cycle and released right after it.
    applyStimulus(12'h050, 12'h004, 12'h050, 12'h004, 12'h050, 12'h004, 1'b1);
    max_clr = 1'b1;
    fork
      runFrames(1, 1);
      clearOnPublish();
    join
    checkOutput("max_after_clr", 64'(max_out), 64'h004050);

    // Enable dropped mid-frame: the frame still completes, then the sequencer goes idle.
    applyStimulus(12'hFFF, 12'h000, 12'hFFF, 12'h000, 12'hFFF, 12'h004, 1'b1);
    runFrames(1, 5);
    checkOutput("stop_adc_cs", 64'(adc_cs), 64'd1);
    checkOutput("stop_adc_clk", 64'(adc_clk), 64'd1);
    fall_snap = clk_fall_count;
    repeat (40) @(negedge clk);
    checkOutput("stop_no_strobes", 64'(clk_fall_count - fall_snap), 64'd0);
    checkOutput("stop_busy", 64'(busy), 64'd0);

    // Reset in slot 8 abandons the frame without a publish.
    applyStimulus(12'h3C3, 12'hC3C, 12'h000, 12'h000, 12'h000, 12'h000, 1'b0);
    ready_snap = ready_count;
    enable = 1'b1;
    waitCsFall();
    repeat (7 * CLK_DIV) @(negedge clk);
    reset  = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    checkOutput("midrst_adc_cs", 64'(adc_cs), 64'd1);
    checkOutput("midrst_ready", 64'(ready), 64'd0);
    checkOutput("midrst_data", 64'(data_out), 64'd0);
    checkOutput("midrst_max", 64'(max_out), 64'd0);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("midrst_no_publish", 64'(ready_count - ready_snap), 64'd0);
    checkOutput("ready_pulses", 64'(ready_count), 64'd6);
`endif

    checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
